// File: rtl/cs151_isa_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder paths.
// Holds the ALU op codes, opcode/funct constants and an encode function
// that returns {legal, word} for an R-type or I-type ALU request.
package cs151_isa_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SLT = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    function automatic enc_t encode(
        input logic        itype,
        input logic [3:0]  aluop,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        enc_t       r;
        logic [2:0] f3;
        logic [6:0] f7;
        f3      = F3_ADD;
        f7      = F7_BASE;
        r.legal = 1'b1;
        case (aluop)
            ALU_AND: f3 = F3_AND;
            ALU_OR:  f3 = F3_OR;
            ALU_ADD: f3 = F3_ADD;
            ALU_XOR: f3 = F3_XOR;
            ALU_SLT: f3 = F3_SLT;
            ALU_SUB: begin
                // SUB has no immediate form
                f3      = F3_ADD;
                f7      = F7_SUB;
                r.legal = !itype;
            end
            default: r.legal = 1'b0;
        endcase
        r.word = itype ? {imm, rs1, f3, rd, OPC_ITYPE}
                       : {f7, rs2, rs1, f3, rd, OPC_RTYPE};
        return r;
    endfunction

endpackage

// File: rtl/cs151_inst_fifo.sv
// DEPTH x WIDTH synchronous FIFO with synchronous flush.
// Ports: clk, rst_n (async active-low), push/wdata, pop, flush,
//        rdata (head, 0 when empty), full, empty, valid (registered
//        non-empty), level (occupancy).
// Push is dropped when full, pop when empty; flush overrides both.
module cs151_inst_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        level_d = level_q;
        if (flush)                  level_d = '0;
        else if (push_ok && !pop_ok) level_d = level_q + 1'b1;
        else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end

    // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            valid_q <= (level_d != '0);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    // Storage is not reset; masking keeps the head at 0 while empty.
    assign rdata = valid_q ? mem_q[rd_ptr_q] : '0;
    assign valid = valid_q;
    assign level = level_q;

endmodule

// File: rtl/cs151_inst_encoder.sv
// Encodes ALU instruction requests into RV32I R/I-type words, buffers
// them in a FIFO and issues them over a valid/ready interface.
// Ports: clk, rst_n (async active-low); request side in_valid/in_ready
//        with in_itype, in_aluop, in_rd, in_rs1, in_rs2, in_imm; flush;
//        issue side out_valid/out_ready/inst; err (one-cycle pulse on a
//        rejected illegal request); level (FIFO occupancy).
// Macro CS151_INST_COUNT_EN adds issued_cnt[CNT_W-1:0], a wrapping count
// of completed output handshakes that survives flush.
module cs151_inst_encoder
    import cs151_isa_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_itype,
    input  logic [3:0]             in_aluop,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [11:0]            in_imm,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            inst,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
`ifdef CS151_INST_COUNT_EN
    ,
    output logic [CNT_W-1:0]       issued_cnt
`endif
);

    enc_t enc;
    logic fifo_full, fifo_empty;
    logic accept, push, pop;
    logic err_q;

    assign enc = encode(in_itype, in_aluop, in_rd, in_rs1, in_rs2, in_imm);

    // No pass-through when full: in_ready never depends on out_ready.
    assign in_ready = !fifo_full && !flush;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc.legal;
    assign pop      = out_ready && !fifo_empty;

    cs151_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (enc.word),
        .pop   (pop),
        .flush (flush),
        .rdata (inst),
        .full  (fifo_full),
        .empty (fifo_empty),
        .valid (out_valid),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= accept && !enc.legal;
    end
    assign err = err_q;

`ifdef CS151_INST_COUNT_EN
    logic [CNT_W-1:0] cnt_q;

    // A pop coinciding with flush is discarded, so it is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt_q <= '0;
        else if (pop && !flush)        cnt_q <= cnt_q + 1'b1;
    end
    assign issued_cnt = cnt_q;
`else
    // CNT_W only sizes the counter; nothing to build without it.
    if (CNT_W == 0) begin : g_no_cnt
    end
`endif

endmodule

// File: tb/tb_cs151_inst_encoder.sv
module tb_cs151_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_itype = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [3:0]  in_aluop = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [11:0] in_imm = '0;
    logic        in_ready, out_valid, err;
    logic [31:0] inst;
    logic [2:0]  level;
`ifdef CS151_INST_COUNT_EN
    logic [CNT_W-1:0] issued_cnt;
`endif

    always #5 clk = ~clk;

    cs151_inst_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_itype  (in_itype),
        .in_aluop  (in_aluop),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err),
        .level     (level)
`ifdef CS151_INST_COUNT_EN
        ,
        .issued_cnt(issued_cnt)
`endif
    );

    int unsigned n_pass = 0, n_total = 0;
    logic [31:0] q[$];
    logic        exp_err = 1'b0;
    int unsigned exp_cnt = 0;

    // Reference encoder built from the field tables with plain arithmetic.
    function automatic logic [32:0] ref_encode(input logic it, input logic [3:0] op,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [11:0] imm);
        int unsigned f3, f7;
        logic        lg;
        logic [31:0] w;
        lg = 1'b1; f7 = 0; f3 = 0;
        case (op)
            4'd0: f3 = 7;
            4'd1: f3 = 6;
            4'd2: f3 = 0;
            4'd3: f3 = 4;
            4'd6: begin f3 = 0; f7 = 32; lg = !it; end
            4'd7: f3 = 2;
            default: lg = 1'b0;
        endcase
        if (it) w = 32'(imm) * 32'h100000 + 32'(rs1) * 32'h8000 + f3 * 32'h1000
                    + 32'(rd) * 32'h80 + 32'd19;
        else    w = f7 * 32'h2000000 + 32'(rs2) * 32'h100000 + 32'(rs1) * 32'h8000
                    + f3 * 32'h1000 + 32'(rd) * 32'h80 + 32'd51;
        return {lg, w};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic check_outs();
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        chk("inst", inst, (q.size() != 0) ? q[0] : 32'h0);
        chk("level", 32'(level), 32'(q.size()));
        chk("err", {31'b0, err}, {31'b0, exp_err});
`ifdef CS151_INST_COUNT_EN
        chk("issued_cnt", 32'(issued_cnt), exp_cnt % (1 << CNT_W));
`endif
    endtask

    // Called at posedge+1 with inputs set; advances one clock.
    task automatic tick();
        logic rdy_e, acc, pop;
        logic [32:0] e;
        #1;
        rdy_e = (q.size() < DEPTH) && !flush;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy_e});
        acc = in_valid && rdy_e;
        pop = (q.size() > 0) && out_ready && !flush;
        e = ref_encode(in_itype, in_aluop, in_rd, in_rs1, in_rs2, in_imm);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop) begin void'(q.pop_front()); exp_cnt++; end
            if (acc && e[32]) q.push_back(e[31:0]);
        end
        exp_err = acc && !e[32];
        #1;
        check_outs();
    endtask

    task automatic set_req(input logic v, input logic it, input logic [3:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [11:0] imm);
        in_valid = v; in_itype = it; in_aluop = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; out_ready = 1'b0;
        q.delete(); exp_err = 1'b0; exp_cnt = 0;
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    typedef struct {
        logic        it;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [31:0] word;
        logic        legal;
    } vec_t;

    vec_t tbl[9];
    logic [3:0] legal_ops[6];
    logic [32:0] e;

    initial begin
        tbl[0] = '{0, 4'b0010, 5'd1,  5'd2,  5'd3,  12'h000, 32'h003100B3, 1};
        tbl[1] = '{1, 4'b0010, 5'd5,  5'd0,  5'd9,  12'hFFF, 32'hFFF00293, 1};
        tbl[2] = '{0, 4'b0110, 5'd1,  5'd2,  5'd3,  12'h000, 32'h403100B3, 1};
        tbl[3] = '{0, 4'b0000, 5'd31, 5'd31, 5'd31, 12'h000, 32'h01FFFFB3, 1};
        tbl[4] = '{1, 4'b0011, 5'd3,  5'd4,  5'd0,  12'h123, 32'h12324193, 1};
        tbl[5] = '{0, 4'b0111, 5'd2,  5'd5,  5'd6,  12'h000, 32'h0062A133, 1};
        tbl[6] = '{1, 4'b0001, 5'd0,  5'd1,  5'd0,  12'h800, 32'h8000E013, 1};
        tbl[7] = '{1, 4'b0110, 5'd1,  5'd2,  5'd3,  12'h005, 32'h00000000, 0};
        tbl[8] = '{0, 4'b1111, 5'd1,  5'd2,  5'd3,  12'h000, 32'h00000000, 0};
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7};

        #2;
        do_reset();

        // Table vectors: one request, check head/err, then drain.
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_req(1, tbl[i].it, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            tick();
            chk("tbl_inst", inst, tbl[i].legal ? tbl[i].word : 32'h0);
            chk("tbl_err", {31'b0, err}, {31'b0, !tbl[i].legal});
            set_req(0, 0, 0, 0, 0, 0, 0);
            tick();
            chk("tbl_drain_level", 32'(level), 32'd0);
        end

        // Backpressure: five pushes into a four-deep FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1, 0, 4'd2, 5'(i + 1), 5'd2, 5'd3, 0);
            tick();
        end
        chk("full_level", 32'(level), 32'd4);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        // Pop with a push pending: still not ready while full.
        out_ready = 1'b1;
        #1;
        chk("full_no_passthru", {31'b0, in_ready}, 32'd0);
        set_req(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            e = ref_encode(0, 4'd2, 5'(i + 1), 5'd2, 5'd3, 0);
            chk("order", inst, e[31:0]);
            tick();
        end

        // Simultaneous push and pop at level 2.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1, 1, 4'd3, 5'(i + 7), 5'd1, 0, 12'(i));
            tick();
        end
        out_ready = 1'b1;
        set_req(1, 0, 4'd7, 5'd9, 5'd4, 5'd5, 0);
        tick();
        chk("pushpop_level", 32'(level), 32'd2);
        set_req(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Flush at level 3 with a concurrent request.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1, 0, 4'd0, 5'(i + 1), 5'd1, 5'd1, 0);
            tick();
        end
        flush = 1'b1;
        set_req(1, 0, 4'd2, 5'd10, 5'd1, 5'd1, 0);
        out_ready = 1'b1;
        tick();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset mid-stream with an err pulse in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1, 0, 4'd1, 5'(i + 3), 5'd1, 5'd2, 0);
            tick();
        end
        set_req(1, 1, 4'd6, 5'd1, 5'd1, 5'd1, 0);
        tick();
        chk("pre_reset_err", {31'b0, err}, 32'd1);
        #2;
        do_reset();

`ifdef CS151_INST_COUNT_EN
        // Counter: 3 issues, flush, 2 issues, then wrap at all-ones.
        for (int i = 0; i < 3; i++) begin
            set_req(1, 0, 4'd2, 5'(i), 5'd0, 5'd0, 0);
            tick();
        end
        set_req(0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_req(1, 0, 4'd2, 5'(i), 5'd0, 5'd0, 0);
            tick();
            set_req(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("cnt_after_flush", 32'(issued_cnt), 32'd5);
        for (int i = 0; i < 3; i++) begin
            set_req(1, 0, 4'd2, 5'(i), 5'd0, 5'd0, 0);
            tick();
            set_req(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        chk("cnt_wrap", 32'(issued_cnt), 32'd0);
`endif

        // Randomised traffic against the queue model.
        for (int n = 0; n < 500; n++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_itype  = 1'($urandom_range(0, 1));
            in_aluop  = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 5)]
                                                   : 4'($urandom_range(0, 15));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = 12'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
